// File: rtl/mt_pkg.sv
// Shared MT19937 constants and types used by the seeder and the twister.
// The index type is sized for N=624 and is used for both the state index and the recurrence addend.
package mt_pkg;
  localparam int W = 32;
  localparam int N = 624;
  localparam int M = 397;
  localparam logic [31:0] F = 32'd1812433253;

  localparam logic [31:0] MATRIX_A   = 32'h9908B0DF;
  localparam logic [31:0] UPPER_MASK = 32'h80000000;
  localparam logic [31:0] LOWER_MASK = 32'h7FFFFFFF;
  localparam logic [31:0] TEMPER_B   = 32'h9D2C5680;
  localparam logic [31:0] TEMPER_C   = 32'hEFC60000;
  localparam int TEMPER_U = 11;
  localparam int TEMPER_S = 7;
  localparam int TEMPER_T = 15;
  localparam int TEMPER_L = 18;

  localparam int IDX_W = 10;
  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/mt_seed_step.sv
// One step of the MT19937 seeding recurrence: x_next = F*(x ^ (x>>30)) + idx, mod 2^W.
// idx is the index of the word being produced, zero-extended before the add.
module mt_seed_step #(
  parameter int          W = 32,
  parameter logic [31:0] F = 32'd1812433253
) (
  input  logic [W-1:0]               x_prev,
  input  logic [mt_pkg::IDX_W-1:0]   idx,
  output logic [W-1:0]               x_next
);
  logic [W-1:0] mixed;
  logic [W-1:0] prod;

  assign mixed  = x_prev ^ (x_prev >> 30);
  assign prod   = F[W-1:0] * mixed;
  assign x_next = prod + {{(W-mt_pkg::IDX_W){1'b0}}, idx};
endmodule

// File: rtl/mt_seeder.sv
// Expands a seed into the N-word MT19937 initial state and streams it in index order.
// value/load_value form a valid/ready pair with load_ready: a word moves when both are high, otherwise everything holds.
module mt_seeder #(
  parameter int          W = 32,
  parameter int          N = 624,
  parameter logic [31:0] F = 32'd1812433253
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] seed,
  input  logic         start,
  input  logic         load_ready,
  output logic [W-1:0] value,
  output logic         load_value,
  output logic         busy,
  output logic         done
);
  import mt_pkg::*;

  localparam idx_t LAST_IDX = idx_t'(N-1);

  state_t       state_q, state_d;
  logic [W-1:0] x_q, x_d;
  logic [W-1:0] x_next;
  idx_t         idx_q, idx_d;
  idx_t         idx_inc;

  assign idx_inc = idx_q + idx_t'(1);

  mt_seed_step #(
    .W (W),
    .F (F)
  ) u_step (
    .x_prev (x_q),
    .idx    (idx_inc),
    .x_next (x_next)
  );

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          x_d     = seed;
          idx_d   = '0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        // The last word is not followed by a recurrence step, so idx never passes N-1.
        if (load_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            x_d   = x_next;
            idx_d = idx_inc;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      idx_q   <= idx_d;
    end
  end

  // Outputs decode straight from state so an asynchronous reset clears them at once.
  assign load_value = (state_q == EMIT);
  assign busy       = (state_q == EMIT);
  assign done       = (state_q == DONE);
  assign value      = (state_q == EMIT) ? x_q : '0;
endmodule

// File: tb/tb_mt_seeder.sv
// Directed bench for mt_seeder: hand-computed words, a seeding-recurrence scoreboard,
// and an MT19937 twist/temper of the captured state against the reference outputs.
module tb_mt_seeder;
  localparam int N = 624;

  logic        clk;
  logic        rst;
  logic [31:0] seed;
  logic        start;
  logic        load_ready;
  logic [31:0] value;
  logic        load_value;
  logic        busy;
  logic        done;

  int n_chk;
  int n_fail;
  int done_cyc;

  logic [31:0] acc_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] ref_q[$];

  mt_seeder #(
    .W (32),
    .N (N),
    .F (32'd1812433253)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .seed       (seed),
    .start      (start),
    .load_ready (load_ready),
    .value      (value),
    .load_value (load_value),
    .busy       (busy),
    .done       (done)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic void build_exp(input logic [31:0] s);
    logic [31:0] x;
    logic [63:0] p;
    exp_q.delete();
    x = s;
    for (int i = 0; i < N; i++) begin
      exp_q.push_back(x);
      p = 64'd1812433253 * {32'd0, x ^ (x >> 30)};
      x = p[31:0] + 32'(i + 1);
    end
  endfunction

  function automatic logic [31:0] temper(input logic [31:0] y_in);
    logic [31:0] y;
    y = y_in;
    y = y ^ (y >> 11);
    y = y ^ ((y << 7) & 32'h9D2C5680);
    y = y ^ ((y << 15) & 32'hEFC60000);
    y = y ^ (y >> 18);
    return y;
  endfunction

  // k-th twister output (k < 5) computed from the untwisted captured state.
  function automatic logic [31:0] mt_out(input int k);
    logic [31:0] y;
    logic [31:0] m;
    y = (acc_q[k] & 32'h80000000) | (acc_q[k+1] & 32'h7FFFFFFF);
    m = acc_q[k+397] ^ (y >> 1) ^ (y[0] ? 32'h9908B0DF : 32'h0);
    return temper(m);
  endfunction

  task automatic compare_queue(input string tag, input logic [31:0] want_q[$]);
    check({tag, "_count"}, 32'(acc_q.size()), 32'(want_q.size()));
    for (int i = 0; i < acc_q.size() && i < want_q.size(); i++)
      check($sformatf("%s_w%0d", tag, i), acc_q[i], want_q[i]);
  endtask

  // Driver: start a seeding run and collect accepted words until done, a reset abort, or a cycle bound.
  task automatic run_stream(input logic [31:0] s, input bit rnd, input int poke_at,
                            input int abort_at);
    int          cyc;
    bit          pend;
    bit          poked;
    logic [31:0] held;
    acc_q.delete();
    done_cyc = -1;
    pend     = 1'b0;
    poked    = 1'b0;
    held     = '0;
    @(negedge clk);
    seed       = s;
    start      = 1'b1;
    load_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    seed  = 32'hDEADBEEF;
    cyc   = 1;
    check("first_load_value", {31'd0, load_value}, 32'd1);
    check("first_value", value, s);
    check("first_busy", {31'd0, busy}, 32'd1);
    while (cyc < 4000) begin
      if (pend) begin
        check("hold_value", value, held);
        check("hold_load_value", {31'd0, load_value}, 32'd1);
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (abort_at >= 0 && acc_q.size() == abort_at) begin
        #2 rst = 1'b1;
        #1;
        check("abort_value", value, 32'd0);
        check("abort_load_value", {31'd0, load_value}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_abort_load_value", {31'd0, load_value}, 32'd0);
        return;
      end
      start = 1'b0;
      if (poke_at >= 0 && !poked && acc_q.size() == poke_at) begin
        start = 1'b1;
        seed  = 32'h12345678;
        poked = 1'b1;
      end
      load_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (load_value && load_ready) acc_q.push_back(value);
      pend = load_value && !load_ready;
      held = value;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (done_cyc < 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  // After the done cycle: optional start during DONE, then done must drop and no load resumes.
  task automatic after_done(input bit start_on_done);
    start = start_on_done;
    seed  = 32'h00000005;
    @(negedge clk);
    start = 1'b0;
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_load_value", {31'd0, load_value}, 32'd0);
    @(negedge clk);
    check("idle_load_value2", {31'd0, load_value}, 32'd0);
  endtask

  initial begin
    n_chk      = 0;
    n_fail     = 0;
    rst        = 1'b1;
    seed       = '0;
    start      = 1'b0;
    load_ready = 1'b0;
    #1;
    check("rst_value", value, 32'd0);
    check("rst_load_value", {31'd0, load_value}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // seed 5489, load_ready held high
    run_stream(32'd5489, 1'b0, -1, -1);
    check("s5489_word0", acc_q.size() > 0 ? acc_q[0] : 32'hX, 32'h00001571);
    check("s5489_word1", acc_q.size() > 1 ? acc_q[1] : 32'hX, 32'h4D98EE96);
    check("s5489_done_cycle", 32'(done_cyc), 32'd625);
    build_exp(32'd5489);
    compare_queue("s5489", exp_q);
    if (acc_q.size() == N) begin
      check("mt_out0", mt_out(0), 32'hD091BB5C);
      check("mt_out1", mt_out(1), 32'h22AE9EF6);
      check("mt_out2", mt_out(2), 32'hE7E1FAEE);
      check("mt_out3", mt_out(3), 32'hD5C31F79);
      check("mt_out4", mt_out(4), 32'h2082352C);
    end
    ref_q = acc_q;
    after_done(1'b0);

    // seed 0, with a start issued in the DONE cycle that must be ignored
    run_stream(32'd0, 1'b0, -1, -1);
    check("s0_word0", acc_q.size() > 0 ? acc_q[0] : 32'hX, 32'h00000000);
    check("s0_word1", acc_q.size() > 1 ? acc_q[1] : 32'hX, 32'h00000001);
    check("s0_word2", acc_q.size() > 2 ? acc_q[2] : 32'hX, 32'h6C078967);
    check("s0_count", 32'(acc_q.size()), 32'd624);
    after_done(1'b1);

    // seed 5489 with random back-pressure
    run_stream(32'd5489, 1'b1, -1, -1);
    compare_queue("bp", ref_q);
    after_done(1'b0);

    // start re-pulsed at word 100 with another seed
    run_stream(32'd5489, 1'b0, 100, -1);
    compare_queue("restart_ignored", ref_q);
    check("restart_done_cycle", 32'(done_cyc), 32'd625);
    after_done(1'b0);

    // asynchronous reset at word 300, then a clean restart
    run_stream(32'd5489, 1'b0, -1, 300);
    check("abort_words", 32'(acc_q.size()), 32'd300);
    run_stream(32'd5489, 1'b0, -1, -1);
    check("rerun_word0", acc_q.size() > 0 ? acc_q[0] : 32'hX, 32'h00001571);
    compare_queue("rerun", ref_q);
    after_done(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
